// File: rtl/matrix_op_sequencer_if.sv
// rtl/matrix_op_sequencer_if.sv - command, buffer and ALU signal bundle for the matrix op sequencer.
interface matrix_op_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 5
);
  logic          start;
  logic [2:0]    op;
  logic [2:0]    size;
  logic [DW-1:0] scalar;
  logic          busy;
  logic          done;
  logic          err;
  logic          rd_en;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_r1;
  logic [DW-1:0] alu_r2;
  logic [2:0]    alu_s;
  logic [DW-1:0] alu_result;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport slave (
    input  start, op, size, scalar, a_data, b_data, alu_result,
    output busy, done, err, rd_en, a_addr, b_addr,
           alu_op, alu_r1, alu_r2, alu_s, wr_en, wr_addr, wr_data
  );

  modport master (
    output start, op, size, scalar, a_data, b_data, alu_result,
    input  busy, done, err, rd_en, a_addr, b_addr,
           alu_op, alu_r1, alu_r2, alu_s, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// rtl/matrix_op_sequencer.sv - walks an N x N element-wise matrix command, one element per cycle.
// Reads are issued from RUN; a one-deep {valid, idx} pipeline lines writes up with sync-RAM data.
module matrix_op_sequencer #(
  parameter int DW   = 8,
  parameter int AW   = 5,
  parameter int NMAX = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  matrix_op_sequencer_if.slave  bus
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MULTM = 3'b010;
  localparam logic [2:0] OP_MULR  = 3'b011;
  localparam logic [2:0] OP_DETM  = 3'b100;
  localparam logic [2:0] OP_TRANS = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t        state_q;
  logic [2:0]    op_q, n_q, row_q, col_q;
  logic [DW-1:0] scalar_q;
  logic          busy_q, done_q, err_q, rd_en_q, valid_q;
  logic [AW-1:0] a_addr_q, b_addr_q, idx_q;

  logic          last_col_d, last_d, cmd_ok_d;
  logic [2:0]    row_d, col_d;
  logic [AW-1:0] lin_d, trans_d;

  always_comb begin
    last_col_d = (col_q == n_q - 3'd1);
    last_d     = last_col_d && (row_q == n_q - 3'd1);
    row_d      = last_col_d ? row_q + 3'd1 : row_q;
    col_d      = last_col_d ? 3'd0 : col_q + 3'd1;
    lin_d      = AW'(row_d) * AW'(n_q) + AW'(col_d);
    trans_d    = AW'(col_d) * AW'(n_q) + AW'(row_d);
    cmd_ok_d   = (bus.op != OP_MULTM) && (bus.op != OP_DETM) &&
                 (bus.size >= 3'd2) && (bus.size <= 3'(NMAX));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      n_q      <= '0;
      row_q    <= '0;
      col_q    <= '0;
      scalar_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      valid_q  <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      idx_q    <= '0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            n_q      <= bus.size;
            scalar_q <= bus.scalar;
            busy_q   <= 1'b1;
            if (cmd_ok_d) begin
              state_q  <= S_RUN;
              rd_en_q  <= (bus.op != OP_CLEAR);
              row_q    <= '0;
              col_q    <= '0;
              a_addr_q <= '0;
              b_addr_q <= '0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // b_addr always carries the row-major index of the element just issued
          valid_q <= 1'b1;
          idx_q   <= b_addr_q;
          if (last_d) begin
            state_q <= S_FLUSH;
            rd_en_q <= 1'b0;
          end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            b_addr_q <= lin_d;
            a_addr_q <= (op_q == OP_TRANS) ? trans_d : lin_d;
          end
        end
        S_FLUSH: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.a_addr  = a_addr_q;
  assign bus.b_addr  = b_addr_q;
  assign bus.alu_op  = op_q;
  assign bus.alu_s   = n_q;
  assign bus.wr_en   = valid_q;
  assign bus.wr_addr = idx_q;

  always_comb begin
    bus.alu_r1  = '0;
    bus.alu_r2  = '0;
    bus.wr_data = '0;
    if (valid_q) begin
      bus.alu_r1 = bus.a_data;
      case (op_q)
        OP_ADD, OP_SUB: bus.alu_r2 = bus.b_data;
        OP_MULR:        bus.alu_r2 = scalar_q;
        default:        bus.alu_r2 = '0;
      endcase
      if (op_q != OP_CLEAR) bus.wr_data = bus.alu_result;
    end
  end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// tb/tb_matrix_op_sequencer.sv - directed and random commands against a behavioural buffer/ALU model.
module tb_matrix_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_op_sequencer_if #(.DW(8), .AW(5)) bus ();

  matrix_op_sequencer #(.DW(8), .AW(5), .NMAX(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  logic [7:0] res   [32];
  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] r1, input logic [7:0] r2);
    case (op)
      3'b000:  return r1 + r2;
      3'b001:  return r1 - r2;
      3'b011:  return r1 * r2;
      3'b101:  return r1;
      3'b110:  return ~r1;
      3'b111:  return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_r1, bus.alu_r2);

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_data <= mem_a[bus.a_addr];
      bus.b_data <= mem_b[bus.b_addr];
    end
    if (bus.wr_en) res[bus.wr_addr] <= bus.wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  // Drives one command at a negedge and checks every cycle until the sequencer is idle again.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] n, input logic [7:0] sc, input bit pulse);
    int nn, k, row, col, aidx;
    bit legal;
    logic [7:0] r2;
    legal = (op != 3'b010) && (op != 3'b100) && (n >= 3'd2) && (n <= 3'd5);
    bus.start = 1'b1; bus.op = op; bus.size = n; bus.scalar = sc;
    @(posedge clk);
    @(negedge clk);
    if (!legal) begin
      bus.start = 1'b0;
      chk("rej_done", bus.done, 1);
      chk("rej_err", bus.err, 1);
      chk("rej_busy", bus.busy, 1);
      chk("rej_rd_en", bus.rd_en, 0);
      chk("rej_wr_en", bus.wr_en, 0);
      @(negedge clk);
      chk("rej_busy_after", bus.busy, 0);
      chk("rej_done_after", bus.done, 0);
      chk("rej_rd_after", bus.rd_en, 0);
      return;
    end
    nn = int'(n) * int'(n);
    for (int c = 1; c <= nn + 2; c++) begin
      if (pulse) begin
        bus.start = 1'b1; bus.op = 3'($urandom); bus.size = 3'($urandom); bus.scalar = 8'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      chk("busy", bus.busy, 1);
      chk("done", bus.done, (c == nn + 2) ? 1 : 0);
      chk("alu_op", bus.alu_op, op);
      chk("alu_s", bus.alu_s, n);
      if (c <= nn) begin
        k = c - 1; row = k / int'(n); col = k % int'(n);
        chk("rd_en", bus.rd_en, (op != 3'b111) ? 1 : 0);
        if (op != 3'b111) begin
          chk("b_addr", bus.b_addr, k);
          chk("a_addr", bus.a_addr, (op == 3'b101) ? col * int'(n) + row : k);
        end
      end else begin
        chk("rd_en_idle", bus.rd_en, 0);
      end
      if (c >= 2 && c <= nn + 1) begin
        k = c - 2; row = k / int'(n); col = k % int'(n);
        aidx = (op == 3'b101) ? col * int'(n) + row : k;
        case (op)
          3'b000, 3'b001: r2 = mem_b[k];
          3'b011:         r2 = sc;
          default:        r2 = 8'h00;
        endcase
        chk("wr_en", bus.wr_en, 1);
        chk("wr_addr", bus.wr_addr, k);
        if (op == 3'b111) begin
          chk("wr_data_clear", bus.wr_data, 0);
        end else begin
          chk("alu_r1", bus.alu_r1, mem_a[aidx]);
          chk("alu_r2", bus.alu_r2, r2);
          chk("wr_data", bus.wr_data, alu_fn(op, mem_a[aidx], r2));
        end
      end else begin
        chk("wr_en_idle", bus.wr_en, 0);
        chk("alu_r1_idle", bus.alu_r1, 0);
        chk("alu_r2_idle", bus.alu_r2, 0);
      end
      if (c == nn + 2) chk("err", bus.err, 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("busy_after", bus.busy, 0);
    chk("done_after", bus.done, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops [8];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b011; ops[3] = 3'b101;
    ops[4] = 3'b110; ops[5] = 3'b111; ops[6] = 3'b010; ops[7] = 3'b100;
    bus.start = 1'b0; bus.op = '0; bus.size = '0; bus.scalar = '0;
    for (int i = 0; i < 32; i++) res[i] = 8'hEE;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_a_addr", bus.a_addr, 0);
    chk("rst_b_addr", bus.b_addr, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_alu_op", bus.alu_op, 0);
    chk("rst_alu_s", bus.alu_s, 0);
    chk("rst_alu_r1", bus.alu_r1, 0);
    chk("rst_alu_r2", bus.alu_r2, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'(i + 1);
      mem_b[i] = 8'(10 * (i + 1));
    end
    run_cmd(3'b000, 3'd2, 8'd0, 1'b0);
    chk("add_res0", res[0], 11);
    chk("add_res1", res[1], 22);
    chk("add_res2", res[2], 33);
    chk("add_res3", res[3], 44);

    fill_rand();
    run_cmd(3'b101, 3'd3, 8'd0, 1'b0);
    fill_rand();
    run_cmd(3'b011, 3'd2, 8'd3, 1'b0);

    run_cmd(3'b010, 3'd3, 8'd0, 1'b0);
    run_cmd(3'b100, 3'd3, 8'd0, 1'b0);
    run_cmd(3'b000, 3'd1, 8'd0, 1'b0);
    run_cmd(3'b000, 3'd6, 8'd0, 1'b0);

    fill_rand();
    bus.start = 1'b1; bus.op = 3'b000; bus.size = 3'd5; bus.scalar = '0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_wr_en", bus.wr_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_wr_en", bus.wr_en, 0);
    chk("abort_done", bus.done, 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.wr_en !== 1'b0) chk("abort_quiet", {bus.done, bus.wr_en}, 0);
    end
    fill_rand();
    run_cmd(3'b000, 3'd2, 8'd0, 1'b0);

    fill_rand();
    run_cmd(3'b001, 3'd2, 8'd0, 1'b1);
    run_cmd(3'b111, 3'd2, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) chk("clear_res", res[i], 0);

    fill_rand();
    run_cmd(3'b000, 3'd5, 8'd0, 1'b0);
    for (int t = 0; t < 10; t++) begin
      fill_rand();
      run_cmd(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 8'($urandom), t[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
